// File: rtl/byte_encode_pkg.sv
// byte_encode_pkg: Kyber constants, FSM states and coefficient reduction shared by the encoder.
package byte_encode_pkg;
  localparam int KYBER_CONFIG_Q         = 3329;
  localparam int KYBER_CONFIG_N         = 256;
  localparam int KYBER_CONFIG_POLYBYTES = 384;
  localparam int BEATS = KYBER_CONFIG_N / 4;
  localparam int WORDS = KYBER_CONFIG_POLYBYTES / 8;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  function automatic logic [11:0] reduce12(input logic [11:0] c);
    return (c >= 12'(KYBER_CONFIG_Q)) ? c - 12'(KYBER_CONFIG_Q) : c;
  endfunction
endpackage

// File: rtl/byte_encode_if.sv
// byte_encode_if: coefficient-in / byte-word-out handshake bundle for byte_encode.
interface byte_encode_if;
  logic [47:0] i_coeffs;
  logic        i_coeffs_valid;
  logic        o_coeffs_ready;
  logic [63:0] o_obytes;
  logic        o_obytes_valid;
  logic        i_obytes_ready;
  logic        o_done;
  modport slave (input i_coeffs, i_coeffs_valid, i_obytes_ready,
                 output o_coeffs_ready, o_obytes, o_obytes_valid, o_done);
  modport master (output i_coeffs, i_coeffs_valid, i_obytes_ready,
                  input o_coeffs_ready, o_obytes, o_obytes_valid, o_done);
endinterface

// File: rtl/byte_encode_coeff_pack12.sv
// coeff_pack12: reduces four 12-bit coefficients mod Q and packs them into six Encode_12 bytes.
module coeff_pack12
  import byte_encode_pkg::*;
(
  input  logic [47:0] coeffs_i,
  output logic [47:0] chunk_o
);
  logic [11:0] r [4];
  for (genvar g = 0; g < 4; g++) begin : g_red
    assign r[g] = reduce12(coeffs_i[47-12*g -: 12]);
  end
  assign chunk_o = {r[0][7:0], r[1][3:0], r[0][11:8], r[1][11:4],
                    r[2][7:0], r[3][3:0], r[2][11:8], r[3][11:4]};
endmodule

// File: rtl/byte_encode.sv
// byte_encode: streams a 256-coefficient polynomial as 48 Encode_12 64-bit words.
// A 16-byte MSB-first buffer acts as a 6-byte-in / 8-byte-out gearbox.
module byte_encode
  import byte_encode_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rstn,
  byte_encode_if.slave  bus
);
  state_e       state_q, state_d;
  logic [127:0] buf_q, buf_d, shifted;
  logic [4:0]   fill_q, fill_d, base;
  logic [6:0]   cnt_in_q, cnt_in_d;
  logic [5:0]   cnt_out_q, cnt_out_d;
  logic [47:0]  chunk;
  logic         acc, con;
  coeff_pack12 u_pack (.coeffs_i(bus.i_coeffs), .chunk_o(chunk));
  assign bus.o_coeffs_ready = fill_q <= 5'd10 && cnt_in_q < 7'(BEATS) && state_q != S_DONE;
  assign bus.o_obytes_valid = fill_q >= 5'd8;
  assign bus.o_obytes       = buf_q[127:64];
  assign bus.o_done         = state_q == S_DONE;
  assign acc = bus.i_coeffs_valid && bus.o_coeffs_ready;
  assign con = bus.o_obytes_valid && bus.i_obytes_ready;
  always_comb begin
    shifted   = con ? {buf_q[63:0], 64'd0} : buf_q;
    base      = con ? fill_q - 5'd8 : fill_q;
    // new bytes land just below the last valid byte after any same-cycle drain
    buf_d     = acc ? shifted | ({chunk, 80'd0} >> {base, 3'b000}) : shifted;
    fill_d    = fill_q - (con ? 5'd8 : 5'd0) + (acc ? 5'd6 : 5'd0);
    cnt_in_d  = cnt_in_q + 7'(acc);
    cnt_out_d = cnt_out_q + 6'(con);
    state_d   = (state_q == S_IDLE && acc) ? S_RUN :
                (state_q == S_RUN && con && cnt_out_q == 6'(WORDS - 1)) ? S_DONE :
                (state_q == S_DONE) ? S_IDLE : state_q;
    if (state_q == S_DONE) begin
      buf_d     = '0;
      fill_d    = '0;
      cnt_in_d  = '0;
      cnt_out_d = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      fill_q    <= '0;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      cnt_in_q  <= cnt_in_d;
      cnt_out_q <= cnt_out_d;
    end
  end
endmodule

// File: tb/tb_byte_encode.sv
// tb_byte_encode: scoreboard bench; stimulus queues expected words, a monitor sinks and compares them.
module tb_byte_encode;
  import byte_encode_pkg::*;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  byte_encode_if bif();
  byte_encode dut (.i_clk(clk), .i_rstn(rstn), .bus(bif.slave));
  int n_cmp = 0, n_bad = 0, stall_left = 0, done_cnt = 0;
  bit ignore = 0;
  logic [63:0] exp_q [$];
  logic [11:0] poly [256];
  logic [63:0] d00_t [3] = '{64'h000DD0000DD0000D, 64'hD0000DD0000DD000, 64'h0DD0000DD0000DD0};
  logic [63:0] red_t [3] = '{64'h00E02F00E02F00E0, 64'h2F00E02F00E02F00, 64'hE02F00E02F00E02F};
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // bit-serial Encode_12: coefficient bits laid out LSB-first, byte k = stream bits [8k+7:8k]
  function automatic logic [63:0] ref_word(input int k);
    logic [63:0] w = '0;
    for (int j = 0; j < 8; j++)
      for (int t = 0; t < 8; t++) begin
        int p = 64*k + 8*j + t;
        logic [11:0] c = poly[p/12];
        c = (c >= 12'd3329) ? c - 12'd3329 : c;
        w[56 - 8*j + t] = c[p%12];
      end
    return w;
  endfunction
  task automatic push_ref();
    for (int k = 0; k < 48; k++) exp_q.push_back(ref_word(k));
  endtask
  task automatic send(input int n);
    for (int b = 0; b < n; b++) begin
      int t = 0;
      @(negedge clk);
      bif.i_coeffs = {poly[4*b], poly[4*b+1], poly[4*b+2], poly[4*b+3]};
      bif.i_coeffs_valid = 1;
      while (!bif.o_coeffs_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) chk("beat_timeout", 64'(b), 64'hFFFF);
      @(posedge clk);
    end
    @(negedge clk);
    bif.i_coeffs_valid = 0;
  endtask
  task automatic run(input string name);
    int d0 = done_cnt, t = 0;
    send(64);
    while ((exp_q.size() != 0 || done_cnt == d0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_idle_ready"}, 64'(bif.o_coeffs_ready), 64'd1);
    chk({name, "_idle_valid"}, 64'(bif.o_obytes_valid), 64'd0);
    exp_q.delete();
  endtask
  initial forever begin
    @(negedge clk);
    if (!rstn) continue;
    if (bif.o_done) done_cnt++;
    if (stall_left > 0 && bif.o_obytes_valid) begin
      stall_left--;
      bif.i_obytes_ready = 0;
      if (exp_q.size() != 0) chk("stall_hold", bif.o_obytes, exp_q[0]);
      chk("stall_ready_low", 64'(bif.o_coeffs_ready), 64'd0);
    end else begin
      bif.i_obytes_ready = 1;
      if (bif.o_obytes_valid && !ignore) begin
        if (exp_q.size() == 0) chk("extra_word", bif.o_obytes, 64'hx);
        else chk("word", bif.o_obytes, exp_q.pop_front());
      end
    end
  end
  initial begin
    bif.i_coeffs = '0;
    bif.i_coeffs_valid = 0;
    bif.i_obytes_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_obytes", bif.o_obytes, 64'd0);
    chk("rst_valid", 64'(bif.o_obytes_valid), 64'd0);
    chk("rst_done", 64'(bif.o_done), 64'd0);
    chk("rst_ready", 64'(bif.o_coeffs_ready), 64'd1);
    rstn = 1;
    for (int i = 0; i < 256; i++) poly[i] = 12'd0;
    for (int k = 0; k < 48; k++) exp_q.push_back(64'd0);
    run("zero");
    for (int i = 0; i < 256; i++) poly[i] = 12'(i);
    push_ref();
    exp_q[0] = 64'h0010000230000450;
    exp_q[1] = 64'h000670000890000A;
    run("ramp");
    for (int i = 0; i < 256; i++) poly[i] = 12'hD00;
    for (int k = 0; k < 48; k++) exp_q.push_back(d00_t[k%3]);
    run("q_minus_1");
    for (int i = 0; i < 256; i++) poly[i] = (i % 2) ? 12'hFFF : 12'hD01;
    for (int k = 0; k < 48; k++) exp_q.push_back(red_t[k%3]);
    run("reduce");
    for (int i = 0; i < 256; i++) poly[i] = 12'($urandom);
    push_ref();
    stall_left = 10;
    run("stall");
    chk("stall_consumed", 64'(stall_left), 64'd0);
    ignore = 1;
    for (int i = 0; i < 256; i++) poly[i] = 12'($urandom);
    send(20);
    rstn = 0;
    #1;
    chk("midrst_obytes", bif.o_obytes, 64'd0);
    chk("midrst_valid", 64'(bif.o_obytes_valid), 64'd0);
    chk("midrst_done", 64'(bif.o_done), 64'd0);
    chk("midrst_ready", 64'(bif.o_coeffs_ready), 64'd1);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    ignore = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) poly[i] = 12'($urandom);
    push_ref();
    run("after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/byte_encode.md
# byte_encode

Serialises one Kyber polynomial of 256 canonical 12-bit coefficients into the 384-byte Encode_12 byte string and streams it out as 48 64-bit words. It is the transmit-side counterpart of the byte-to-coefficient parser. It packs 4 coefficients per input beat through a 6-byte-in / 8-byte-out gearbox and handshakes on both sides.

## Interface
- KYBER_CONFIG_Q, 3329 (from configs.v): modulus used for input reduction
- KYBER_CONFIG_N, 256 (from configs.v): coefficients per polynomial
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_coeffs  in  48  4 coefficients; coeff 0 in [47:36], coeff 3 in [11:0]
- i_coeffs_valid  in  1  input beat valid
- o_coeffs_ready  out  1  input beat accepted when valid and ready are both high
- o_obytes  out  64  output word; first byte in [63:56]
- o_obytes_valid  out  1  output word valid
- i_obytes_ready  in  1  output word consumed when valid and ready are both high
- o_done  out  1  one-cycle pulse after the 48th word is consumed

## Operation
- Reduction:
  - Each coefficient c is replaced by c − Q when c ≥ Q, otherwise passed unchanged.
  - This is a single conditional subtract, so 12-bit inputs 0..4095 map into 0..Q−1.
- Packing: for each pair (a, b) of reduced coefficients, produce 3 bytes in order:
  - a[7:0]
  - {b[3:0], a[11:8]}
  - b[11:4]
  - A beat therefore yields 6 bytes, with pair (c0, c1) first.
- Buffer:
  - 128-bit register buf holding MSB-first bytes; fill count `fill` runs 0..16 bytes.
  - o_obytes = buf[127:64].
  - o_obytes_valid = (fill ≥ 8).
- o_coeffs_ready = (fill ≤ 10) && (cnt_in < 64) && state != S_DONE.
  - It depends on registered state only; there is no combinational path from i_obytes_ready.
- Output consumed:
  - buf shifts left 64 bits and fill decreases by 8.
  - Bytes freed at the bottom are zero.
- Input accepted:
  - 6 bytes are written at byte offset fill, or at fill − 8 when an output word is consumed in the same cycle.
  - fill increases by 6.
  - Simultaneous accept and consume: fill ← fill − 2.
- Counters:
  - cnt_in counts accepted beats, 0..64.
  - cnt_out counts consumed words, 0..48.
- FSM:
  - S_IDLE → S_RUN on the first accepted beat.
  - S_RUN → S_DONE when the 48th word is consumed.
  - S_DONE → S_IDLE unconditionally.
  - In S_DONE, o_done = 1 and cnt_in, cnt_out, fill and buf are cleared.
- 384 bytes is divisible by 8, so no residual bytes remain and no flush state is needed.
- Beats offered after cnt_in = 64 and before S_DONE are not accepted: ready stays low.

## Timing
- Reset values:
  - o_obytes = 0, o_obytes_valid = 0, o_done = 0.
  - o_coeffs_ready = 1, because fill = 0 and cnt_in = 0.
  - State S_IDLE; all counters and buf are 0.
- Latency with no stalls:
  - Beats are accepted in cycles 0 and 1.
  - o_obytes_valid rises in cycle 2.
- Output stability:
  - While o_obytes_valid = 1 and i_obytes_ready = 0, o_obytes holds stable.
  - Input continues to be accepted only while fill ≤ 10.
- Steady-state fill sequence with the sink always ready: 0, 6, 12, 4, 10, 8, 6, 12, …
- o_done is asserted in the cycle after the final word handshake.
- The next polynomial may start in the cycle after o_done.
- Reset mid-operation:
  - All state clears immediately.
  - Partial data is discarded.
  - The next beat starts a fresh polynomial.

## Structure
- KYBER_CONFIG_Q and KYBER_CONFIG_N come from the shared configs.v.
- Add KYBER_CONFIG_POLYBYTES = 384 to configs.v.
- One combinational sub-module, coeff_pack12: 48-bit beat in, reduction plus packing, 48-bit (6-byte) chunk out.
- The gearbox, counters and FSM live in byte_encode.

## Test plan
- All coefficients 0, sink always ready -> 48 words of 0x0000000000000000; one o_done pulse; then S_IDLE.
- First two beats are coefficients 0..3 and 4..7 -> word 0 = 0x0010000230000450.
- All coefficients 0xD00 (3328) -> word 0 = 0x000DD0000DD0000D, with the pattern continuing cyclically.
- Reduction cases:
  - Coefficient 0xD01 encodes as 0x000.
  - Coefficient 0xFFF encodes as 0x2FE.
  - Check against a software Encode_12 reference over a full polynomial.
- Sink stalls 10 cycles after the first valid word:
  - o_obytes is held stable.
  - o_coeffs_ready falls once fill > 10.
  - Byte stream is lossless and matches the reference.
- Assert i_rstn low after 20 beats:
  - All outputs return to reset values.
  - A following full polynomial encodes correctly with exactly 48 words.
